// File: rtl/msi_pkg.sv
// Shared MSI protocol definitions: line states, directory message/command codes, controller states.
// The directory side imports this package as well.
package msi_pkg;

    localparam int unsigned NUM_LINES = 4;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'b000,
        ST_I     = 3'b001,
        ST_S     = 3'b010,
        ST_M     = 3'b011
    } lineState_t;

    localparam logic [2:0] MSG_RDMISS   = 3'b001;
    localparam logic [2:0] MSG_WRMISS   = 3'b010;
    localparam logic [2:0] MSG_INV      = 3'b011;
    localparam logic [2:0] MSG_WB       = 3'b100;

    localparam logic [2:0] CMD_INV      = 3'b001;
    localparam logic [2:0] CMD_FETCH    = 3'b010;
    localparam logic [2:0] CMD_FETCHINV = 3'b011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        EVICT  = 3'd2,
        REQ    = 3'd3,
        WAIT   = 3'd4,
        CMD    = 3'd5
    } ctrlState_t;

    function automatic logic lineValid(input logic [2:0] st);
        return (st == ST_S) || (st == ST_M);
    endfunction

endpackage

// File: rtl/msi_line_array.sv
// Four-entry {state, tag, data} store: combinational lookup port, one synchronous write port.
module msi_line_array #(
    parameter int unsigned LINES = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [1:0] lkIdx,
    output logic [2:0] lkState,
    output logic [1:0] lkTag,
    output logic [3:0] lkData,
    input  logic       wrEn,
    input  logic [1:0] wrIdx,
    input  logic [2:0] wrState,
    input  logic [1:0] wrTag,
    input  logic [3:0] wrData
);
    import msi_pkg::*;

    logic [2:0] stateMem [LINES];
    logic [1:0] tagMem   [LINES];
    logic [3:0] dataMem  [LINES];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int unsigned i = 0; i < LINES; i++) begin
                stateMem[i] <= ST_I;
                tagMem[i]   <= '0;
                dataMem[i]  <= '0;
            end
        end else if (wrEn) begin
            stateMem[wrIdx] <= wrState;
            tagMem[wrIdx]   <= wrTag;
            dataMem[wrIdx]  <= wrData;
        end
    end

    assign lkState = stateMem[lkIdx];
    assign lkTag   = tagMem[lkIdx];
    assign lkData  = dataMem[lkIdx];

endmodule

// File: rtl/msi_cache_node.sv
// L1 cache controller, requester end of the MSI directory protocol (4-line direct-mapped).
module msi_cache_node #(
    parameter logic [1:0]  NODE_ID = 2'b00,
    parameter int unsigned LINES   = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       cpu_valid,
    output logic       cpu_ready,
    input  logic       cpu_write,
    input  logic [3:0] cpu_addr,
    input  logic [3:0] cpu_wdata,
    output logic       cpu_done,
    output logic       cpu_hit,
    output logic [3:0] cpu_rdata,
    output logic       req_valid,
    input  logic       req_ready,
    output logic [2:0] req_type,
    output logic [3:0] req_addr,
    output logic [3:0] req_data,
    output logic [1:0] req_proc,
    input  logic       rep_valid,
    input  logic [3:0] rep_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_type,
    input  logic [3:0] cmd_addr,
    output logic       ack_valid,
    output logic       ack_has_data,
    output logic [3:0] ack_data
);
    import msi_pkg::*;

    ctrlState_t state, nextState;
    logic       live;
    logic       reqWrite;
    logic [3:0] reqAddr, reqWdata;
    logic [2:0] reqMsg, msgNxt;
    logic       repHeld;
    logic [3:0] repHeldData, fillData;

    logic [1:0] lkIdx, lkTag, wrIdx, wrTag;
    logic [2:0] lkState, wrState;
    logic [3:0] lkData, wrData;
    logic       wrEn;

    logic       latchReq, cmdFire, doFill, holdRep;
    logic       doneNxt, hitNxt, ackNxt, ackHasNxt;
    logic [3:0] rdataNxt, ackDataNxt;

    msi_line_array #(.LINES(LINES)) uLines (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .lkIdx   (lkIdx),
        .lkState (lkState),
        .lkTag   (lkTag),
        .lkData  (lkData),
        .wrEn    (wrEn),
        .wrIdx   (wrIdx),
        .wrState (wrState),
        .wrTag   (wrTag),
        .wrData  (wrData)
    );

    // A reply that collides with a command is parked and installed the following cycle,
    // so the single write port applies the command first and the fill second.
    assign cmdFire  = cmd_valid && ((state == CMD) || ((state == WAIT) && !repHeld));
    assign lkIdx    = cmdFire ? cmd_addr[1:0] : reqAddr[1:0];
    assign fillData = repHeld ? repHeldData : rep_data;
    assign req_proc = NODE_ID;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState  = state;
        cpu_ready  = 1'b0;
        cmd_ready  = 1'b0;
        req_valid  = 1'b0;
        req_type   = '0;
        req_addr   = '0;
        req_data   = '0;
        wrEn       = 1'b0;
        wrIdx      = reqAddr[1:0];
        wrState    = lkState;
        wrTag      = lkTag;
        wrData     = lkData;
        msgNxt     = reqMsg;
        latchReq   = 1'b0;
        doFill     = 1'b0;
        holdRep    = 1'b0;
        doneNxt    = 1'b0;
        hitNxt     = 1'b0;
        rdataNxt   = '0;
        ackNxt     = 1'b0;
        ackHasNxt  = 1'b0;
        ackDataNxt = '0;

        case (state)
            IDLE: if (live) begin
                if (cmd_valid) begin
                    nextState = CMD;
                end else begin
                    cpu_ready = 1'b1;
                    if (cpu_valid) begin
                        latchReq  = 1'b1;
                        nextState = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (lineValid(lkState) && (lkTag == reqAddr[3:2])) begin
                    if (!reqWrite) begin
                        doneNxt   = 1'b1;
                        hitNxt    = 1'b1;
                        rdataNxt  = lkData;
                        nextState = IDLE;
                    end else if (lkState == ST_M) begin
                        doneNxt   = 1'b1;
                        hitNxt    = 1'b1;
                        wrEn      = 1'b1;
                        wrData    = reqWdata;
                        nextState = IDLE;
                    end else begin
                        msgNxt    = MSG_INV;
                        nextState = REQ;
                    end
                end else begin
                    msgNxt    = reqWrite ? MSG_WRMISS : MSG_RDMISS;
                    nextState = (lkState == ST_M) ? EVICT : REQ;
                end
            end
            EVICT: begin
                req_valid = 1'b1;
                req_type  = MSG_WB;
                req_addr  = {lkTag, reqAddr[1:0]};
                req_data  = lkData;
                if (req_ready) begin
                    wrEn      = 1'b1;
                    wrState   = ST_I;
                    nextState = REQ;
                end
            end
            REQ: begin
                req_valid = 1'b1;
                req_type  = reqMsg;
                req_addr  = reqAddr;
                if (req_ready) nextState = WAIT;
            end
            WAIT: begin
                if (repHeld)        doFill  = 1'b1;
                else if (cmd_valid) holdRep = rep_valid;
                else if (rep_valid) doFill  = 1'b1;
            end
            CMD:     nextState = IDLE;
            default: nextState = IDLE;
        endcase

        if (cmdFire) begin
            cmd_ready = 1'b1;
            ackNxt    = 1'b1;
            wrIdx     = cmd_addr[1:0];
            if (lineValid(lkState) && (lkTag == cmd_addr[3:2])) begin
                case (cmd_type)
                    CMD_INV: begin
                        wrEn    = 1'b1;
                        wrState = ST_I;
                    end
                    CMD_FETCH: if (lkState == ST_M) begin
                        wrEn       = 1'b1;
                        wrState    = ST_S;
                        ackHasNxt  = 1'b1;
                        ackDataNxt = lkData;
                    end
                    CMD_FETCHINV: begin
                        wrEn       = 1'b1;
                        wrState    = ST_I;
                        ackHasNxt  = (lkState == ST_M);
                        ackDataNxt = (lkState == ST_M) ? lkData : '0;
                    end
                    default: ;
                endcase
            end
        end

        if (doFill) begin
            wrEn      = 1'b1;
            wrIdx     = reqAddr[1:0];
            wrTag     = reqAddr[3:2];
            doneNxt   = 1'b1;
            nextState = IDLE;
            if (reqMsg == MSG_RDMISS) begin
                wrState  = ST_S;
                wrData   = fillData;
                rdataNxt = fillData;
            end else begin
                wrState  = ST_M;
                wrData   = reqWdata;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            live         <= 1'b0;
            reqWrite     <= 1'b0;
            reqAddr      <= '0;
            reqWdata     <= '0;
            reqMsg       <= '0;
            repHeld      <= 1'b0;
            repHeldData  <= '0;
            cpu_done     <= 1'b0;
            cpu_hit      <= 1'b0;
            cpu_rdata    <= '0;
            ack_valid    <= 1'b0;
            ack_has_data <= 1'b0;
            ack_data     <= '0;
        end else begin
            live <= 1'b1;
            if (latchReq) begin
                reqWrite <= cpu_write;
                reqAddr  <= cpu_addr;
                reqWdata <= cpu_wdata;
            end
            reqMsg <= msgNxt;
            if (holdRep) begin
                repHeld     <= 1'b1;
                repHeldData <= rep_data;
            end else if (doFill) begin
                repHeld     <= 1'b0;
            end
            cpu_done     <= doneNxt;
            cpu_hit      <= hitNxt;
            cpu_rdata    <= rdataNxt;
            ack_valid    <= ackNxt;
            ack_has_data <= ackHasNxt;
            ack_data     <= ackDataNxt;
        end
    end

endmodule

// File: tb/tb_msi_cache_node.sv
// Directed bench for msi_cache_node: misses, hits, upgrade, eviction, directory commands, reset.
module tb_msi_cache_node;

    logic       Clock, Resetn;
    logic       cpu_valid, cpu_ready, cpu_write;
    logic [3:0] cpu_addr, cpu_wdata;
    logic       cpu_done, cpu_hit;
    logic [3:0] cpu_rdata;
    logic       req_valid, req_ready;
    logic [2:0] req_type;
    logic [3:0] req_addr, req_data;
    logic [1:0] req_proc;
    logic       rep_valid;
    logic [3:0] rep_data;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_type;
    logic [3:0] cmd_addr;
    logic       ack_valid, ack_has_data;
    logic [3:0] ack_data;

    int checks   = 0;
    int failures = 0;

    msi_cache_node #(.NODE_ID(2'b00)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr(req_addr), .req_data(req_data), .req_proc(req_proc),
        .rep_valid(rep_valid), .rep_data(rep_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
        .ack_valid(ack_valid), .ack_has_data(ack_has_data), .ack_data(ack_data)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic w, input logic [3:0] a, input logic [3:0] d, output logic acc);
        acc = 1'b0;
        cpu_valid = 1'b1; cpu_write = w; cpu_addr = a; cpu_wdata = d;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (cpu_ready) acc = 1'b1;
            @(posedge Clock);
            #1;
            if (acc) break;
        end
        cpu_valid = 1'b0;
    endtask

    task automatic serveReq(output logic seen, output logic [2:0] t, output logic [3:0] a, output logic [3:0] d);
        seen = 1'b0; t = '0; a = '0; d = '0;
        for (int i = 0; i < 8; i++) begin
            if (req_valid) begin
                seen = 1'b1; t = req_type; a = req_addr; d = req_data;
                req_ready = 1'b1;
                tick();
                req_ready = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic reply(input logic [3:0] d);
        rep_valid = 1'b1; rep_data = d;
        tick();
        rep_valid = 1'b0; rep_data = '0;
    endtask

    task automatic waitDone(output logic seen, output logic hit, output logic [3:0] rd);
        seen = 1'b0; hit = 1'b0; rd = '0;
        for (int i = 0; i < 8; i++) begin
            if (cpu_done) begin
                seen = 1'b1; hit = cpu_hit; rd = cpu_rdata;
                break;
            end
            tick();
        end
    endtask

    task automatic doCmd(input logic [2:0] t, input logic [3:0] a,
                         output logic seen, output logic hd, output logic [3:0] dat);
        logic hs;
        hs = 1'b0;
        cmd_valid = 1'b1; cmd_type = t; cmd_addr = a;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (cmd_ready) hs = 1'b1;
            @(posedge Clock);
            #1;
            if (hs) break;
        end
        cmd_valid = 1'b0;
        seen = hs && ack_valid; hd = ack_has_data; dat = ack_data;
    endtask

    task automatic test_reset;
        logic [2:0] st;
        Resetn = 1'b1;
        cpu_valid = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
        req_ready = 0; rep_valid = 0; rep_data = 0;
        cmd_valid = 0; cmd_type = 0; cmd_addr = 0;
        #1 Resetn = 1'b0;
        tick(); tick();
        checks++;
        if ({cpu_ready, cpu_done, cpu_hit, cpu_rdata, req_valid, req_type, req_addr, req_data,
             cmd_ready, ack_valid, ack_has_data, ack_data} !== '0) begin
            failures++; $display("FAIL reset_outputs: some output nonzero during reset");
        end
        checks++;
        if (req_proc !== 2'b00) begin failures++; $display("FAIL reset_req_proc: got %b want 00", req_proc); end
        for (int i = 0; i < 4; i++) begin
            st = dut.uLines.stateMem[i];
            checks++;
            if (st !== 3'b001) begin failures++; $display("FAIL reset_line%0d: got %b want 001", i, st); end
        end
        Resetn = 1'b1;
        tick(); tick();
    endtask

    task automatic test_read_miss;
        logic acc, seen, hit; logic [2:0] t; logic [3:0] a, d, rd; logic [2:0] st;
        issue(1'b0, 4'b0001, 4'b0000, acc);
        checks++; if (!acc) begin failures++; $display("FAIL rdmiss_accept: got 0 want 1"); end
        serveReq(seen, t, a, d);
        checks++;
        if (!seen || t !== 3'b001 || a !== 4'b0001 || d !== 4'b0000) begin
            failures++; $display("FAIL rdmiss_req: got seen=%b type=%b addr=%b data=%b want 1 001 0001 0000", seen, t, a, d);
        end
        reply(4'b0010);
        waitDone(seen, hit, rd);
        checks++;
        if (!seen || hit !== 1'b0 || rd !== 4'b0010) begin
            failures++; $display("FAIL rdmiss_done: got seen=%b hit=%b rdata=%b want 1 0 0010", seen, hit, rd);
        end
        st = dut.uLines.stateMem[1];
        checks++; if (st !== 3'b010) begin failures++; $display("FAIL rdmiss_line: got %b want 010", st); end
        tick();
    endtask

    task automatic test_read_hit;
        logic acc, reqSeen;
        issue(1'b0, 4'b0001, 4'b0000, acc);
        reqSeen = req_valid;
        checks++;
        if (cpu_done !== 1'b0) begin failures++; $display("FAIL hit_early: cpu_done got %b want 0 in lookup", cpu_done); end
        tick();
        reqSeen = reqSeen | req_valid;
        checks++;
        if (cpu_done !== 1'b1 || cpu_hit !== 1'b1 || cpu_rdata !== 4'b0010) begin
            failures++; $display("FAIL hit_done: got done=%b hit=%b rdata=%b want 1 1 0010", cpu_done, cpu_hit, cpu_rdata);
        end
        checks++; if (reqSeen !== 1'b0) begin failures++; $display("FAIL hit_noreq: req_valid got %b want 0", reqSeen); end
        tick();
    endtask

    task automatic test_upgrade;
        logic acc, seen, hit; logic [2:0] t; logic [3:0] a, d, rd;
        issue(1'b1, 4'b0001, 4'b0110, acc);
        serveReq(seen, t, a, d);
        checks++;
        if (!seen || t !== 3'b011 || a !== 4'b0001) begin
            failures++; $display("FAIL upg_req: got seen=%b type=%b addr=%b want 1 011 0001", seen, t, a);
        end
        reply(4'b1111);
        waitDone(seen, hit, rd);
        checks++; if (!seen || hit !== 1'b0) begin failures++; $display("FAIL upg_done: got seen=%b hit=%b want 1 0", seen, hit); end
        tick();
        issue(1'b0, 4'b0001, 4'b0000, acc);
        waitDone(seen, hit, rd);
        checks++;
        if (!seen || hit !== 1'b1 || rd !== 4'b0110) begin
            failures++; $display("FAIL upg_reload: got seen=%b hit=%b rdata=%b want 1 1 0110", seen, hit, rd);
        end
        tick();
    endtask

    task automatic test_evict;
        logic acc, seen, hit; logic [2:0] t; logic [3:0] a, d, rd;
        issue(1'b0, 4'b0101, 4'b0000, acc);
        serveReq(seen, t, a, d);
        checks++;
        if (!seen || t !== 3'b100 || a !== 4'b0001 || d !== 4'b0110) begin
            failures++; $display("FAIL evict_wb: got seen=%b type=%b addr=%b data=%b want 1 100 0001 0110", seen, t, a, d);
        end
        serveReq(seen, t, a, d);
        checks++;
        if (!seen || t !== 3'b001 || a !== 4'b0101 || d !== 4'b0000) begin
            failures++; $display("FAIL evict_rdmiss: got seen=%b type=%b addr=%b data=%b want 1 001 0101 0000", seen, t, a, d);
        end
        reply(4'b1010);
        waitDone(seen, hit, rd);
        checks++;
        if (!seen || hit !== 1'b0 || rd !== 4'b1010) begin
            failures++; $display("FAIL evict_done: got seen=%b hit=%b rdata=%b want 1 0 1010", seen, hit, rd);
        end
        tick();
    endtask

    task automatic test_commands;
        logic acc, seen, hit, hd; logic [2:0] t, st; logic [3:0] a, d, rd, dat;
        issue(1'b1, 4'b0001, 4'b0110, acc);
        serveReq(seen, t, a, d);
        checks++;
        if (!seen || t !== 3'b010 || a !== 4'b0001) begin
            failures++; $display("FAIL wrmiss_req: got seen=%b type=%b addr=%b want 1 010 0001", seen, t, a);
        end
        reply(4'b0000);
        waitDone(seen, hit, rd);
        tick();
        doCmd(3'b010, 4'b0001, seen, hd, dat);
        checks++;
        if (!seen || hd !== 1'b1 || dat !== 4'b0110) begin
            failures++; $display("FAIL fetch_ack: got ack=%b has=%b data=%b want 1 1 0110", seen, hd, dat);
        end
        st = dut.uLines.stateMem[1];
        checks++; if (st !== 3'b010) begin failures++; $display("FAIL fetch_line: got %b want 010", st); end
        doCmd(3'b001, 4'b0001, seen, hd, dat);
        checks++;
        if (!seen || hd !== 1'b0 || dat !== 4'b0000) begin
            failures++; $display("FAIL inv_ack: got ack=%b has=%b data=%b want 1 0 0000", seen, hd, dat);
        end
        st = dut.uLines.stateMem[1];
        checks++; if (st !== 3'b001) begin failures++; $display("FAIL inv_line: got %b want 001", st); end

        issue(1'b1, 4'b0011, 4'b1001, acc);
        serveReq(seen, t, a, d);
        reply(4'b0000);
        waitDone(seen, hit, rd);
        tick();
        doCmd(3'b011, 4'b0011, seen, hd, dat);
        checks++;
        if (!seen || hd !== 1'b1 || dat !== 4'b1001) begin
            failures++; $display("FAIL fetchinv_ack: got ack=%b has=%b data=%b want 1 1 1001", seen, hd, dat);
        end
        st = dut.uLines.stateMem[3];
        checks++; if (st !== 3'b001) begin failures++; $display("FAIL fetchinv_line: got %b want 001", st); end

        issue(1'b0, 4'b0010, 4'b0000, acc);
        serveReq(seen, t, a, d);
        reply(4'b0100);
        waitDone(seen, hit, rd);
        tick();
        doCmd(3'b001, 4'b0110, seen, hd, dat);
        st = dut.uLines.stateMem[2];
        checks++;
        if (!seen || hd !== 1'b0 || st !== 3'b010) begin
            failures++; $display("FAIL mismatch_cmd: got ack=%b has=%b line=%b want 1 0 010", seen, hd, st);
        end
    endtask

    task automatic test_cmd_rep_same;
        logic acc, seen, hit; logic [2:0] t, st; logic [3:0] a, d, rd;
        issue(1'b1, 4'b0010, 4'b1100, acc);
        serveReq(seen, t, a, d);
        checks++;
        if (!seen || t !== 3'b011 || a !== 4'b0010) begin
            failures++; $display("FAIL same_upg_req: got seen=%b type=%b addr=%b want 1 011 0010", seen, t, a);
        end
        cmd_valid = 1'b1; cmd_type = 3'b001; cmd_addr = 4'b0010;
        rep_valid = 1'b1; rep_data = 4'b0000;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL same_cmd_ready: got %b want 1", cmd_ready); end
        @(posedge Clock);
        #1;
        cmd_valid = 1'b0; rep_valid = 1'b0;
        checks++;
        if (ack_valid !== 1'b1 || ack_has_data !== 1'b0) begin
            failures++; $display("FAIL same_ack: got ack=%b has=%b want 1 0", ack_valid, ack_has_data);
        end
        waitDone(seen, hit, rd);
        checks++; if (!seen || hit !== 1'b0) begin failures++; $display("FAIL same_done: got seen=%b hit=%b want 1 0", seen, hit); end
        st = dut.uLines.stateMem[2];
        checks++; if (st !== 3'b011) begin failures++; $display("FAIL same_line: got %b want 011", st); end
        tick();
        issue(1'b0, 4'b0010, 4'b0000, acc);
        waitDone(seen, hit, rd);
        checks++;
        if (!seen || hit !== 1'b1 || rd !== 4'b1100) begin
            failures++; $display("FAIL same_reload: got seen=%b hit=%b rdata=%b want 1 1 1100", seen, hit, rd);
        end
        tick();
    endtask

    task automatic test_reset_in_req;
        logic acc, seen, hit; logic [2:0] t, st; logic [3:0] a, d, rd;
        issue(1'b0, 4'b1000, 4'b0000, acc);
        tick();
        checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL rst_req_pre: req_valid got %b want 1", req_valid); end
        Resetn = 1'b0;
        #1;
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL rst_req_drop: req_valid got %b want 0", req_valid); end
        for (int i = 0; i < 4; i++) begin
            st = dut.uLines.stateMem[i];
            checks++;
            if (st !== 3'b001) begin failures++; $display("FAIL rst_line%0d: got %b want 001", i, st); end
        end
        tick();
        Resetn = 1'b1;
        tick(); tick();
        issue(1'b0, 4'b0010, 4'b0000, acc);
        serveReq(seen, t, a, d);
        checks++;
        if (!seen || t !== 3'b001 || a !== 4'b0010) begin
            failures++; $display("FAIL rst_after_req: got seen=%b type=%b addr=%b want 1 001 0010", seen, t, a);
        end
        reply(4'b0011);
        waitDone(seen, hit, rd);
        checks++;
        if (!seen || hit !== 1'b0 || rd !== 4'b0011) begin
            failures++; $display("FAIL rst_after_done: got seen=%b hit=%b rdata=%b want 1 0 0011", seen, hit, rd);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_upgrade();
        test_evict();
        test_commands();
        test_cmd_rep_same();
        test_reset_in_req();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
